// File: rtl/smi_mem_lib_fuzz_test_data_checker.sv
// Fuzz test data checker: compares a read-back burst against a counter pattern
// and reports one result record (error count, first bad index, flags) per test.
module smi_mem_lib_fuzz_test_data_checker #(
  parameter int MaxBurstLength = 8192,
  parameter int TimeoutCycles  = 4096
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        paramsValid,
  input  logic [63:0] paramBaseAddr,
  input  logic [31:0] paramByteLength,
  input  logic [63:0] paramDataInit,
  input  logic [63:0] paramDataIncr,
  output logic        paramsStop,
  input  logic        dataValid,
  input  logic [63:0] dataWord,
  input  logic        dataEof,
  output logic        dataStop,
  output logic        resultValid,
  output logic [31:0] resultErrCount,
  output logic [31:0] resultFirstErrIdx,
  output logic [2:0]  resultFlags,
  input  logic        resultStop
);

  typedef enum logic [1:0] {
    Idle,
    Check,
    Drain,
    Report
  } state_t;

  state_t state, stateNext;

  logic [63:0] expected, incr, cmpMask;
  logic [31:0] wordIdx, errCount, firstErrIdx, wdCount;
  logic [29:0] wordsLeft, wordsInit;
  logic [2:0]  tailBytes, flags;
  logic paramXfer, dataXfer, resultXfer;
  logic isFinal, mismatch, wdExpire, tooLong;
  logic unusedBaseAddr;

  // Base address is carried on the link for the controller's benefit only.
  assign unusedBaseAddr = ^paramBaseAddr;

  assign paramXfer  = paramsValid && !paramsStop;
  assign dataXfer   = dataValid && !dataStop;
  assign resultXfer = resultValid && !resultStop;

  assign tooLong   = paramByteLength > 32'(MaxBurstLength);
  assign wordsInit = {1'b0, paramByteLength[31:3]}
                   + 30'(|paramByteLength[2:0]);
  assign isFinal   = wordsLeft == 30'd1;

  // A short tail word only carries its low tailBytes bytes.
  assign cmpMask  = (isFinal && tailBytes != 3'd0)
                  ? ~({64{1'b1}} << {tailBytes, 3'b000})
                  : {64{1'b1}};
  assign mismatch = ((dataWord ^ expected) & cmpMask) != 64'd0;

  assign wdExpire = (TimeoutCycles != 0) && !dataXfer
                 && (wdCount + 32'd1 == 32'(TimeoutCycles));

  always_ff @(posedge clk) begin
    if (srst) state <= Idle;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle: begin
        if (paramXfer) begin
          if (paramByteLength == 32'd0 || tooLong) stateNext = Report;
          else                                     stateNext = Check;
        end
      end
      Check: begin
        if (dataXfer) begin
          if (isFinal && !dataEof)     stateNext = Drain;
          else if (isFinal || dataEof) stateNext = Report;
        end else if (wdExpire) begin
          stateNext = Report;
        end
      end
      Drain: begin
        if (dataXfer && dataEof) stateNext = Report;
        else if (wdExpire)       stateNext = Report;
      end
      Report: begin
        if (resultXfer) stateNext = Idle;
      end
      default: stateNext = Idle;
    endcase
  end

  always_comb begin
    paramsStop  = 1'b1;
    dataStop    = 1'b1;
    resultValid = 1'b0;
    if (!srst) begin
      paramsStop  = state != Idle;
      dataStop    = !(state == Check || state == Drain);
      resultValid = state == Report;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      expected    <= '0;
      incr        <= '0;
      wordIdx     <= '0;
      wordsLeft   <= '0;
      tailBytes   <= '0;
      errCount    <= '0;
      firstErrIdx <= '1;
      flags       <= '0;
      wdCount     <= '0;
    end else begin
      unique case (state)
        Idle: begin
          if (paramXfer) begin
            expected    <= paramDataInit;
            incr        <= paramDataIncr;
            wordIdx     <= '0;
            wordsLeft   <= wordsInit;
            tailBytes   <= paramByteLength[2:0];
            errCount    <= '0;
            firstErrIdx <= '1;
            flags       <= {2'b00, tooLong};
            wdCount     <= '0;
          end
        end
        Check: begin
          if (dataXfer) begin
            wdCount <= '0;
            if (mismatch) begin
              if (errCount != '1)    errCount    <= errCount + 32'd1;
              if (errCount == 32'd0) firstErrIdx <= wordIdx;
            end
            expected  <= expected + incr;
            wordIdx   <= wordIdx + 32'd1;
            wordsLeft <= wordsLeft - 30'd1;
            if (dataEof != isFinal) flags[1] <= 1'b1;
          end else begin
            wdCount <= wdCount + 32'd1;
            if (wdExpire) flags[2] <= 1'b1;
          end
        end
        Drain: begin
          if (dataXfer) begin
            wdCount <= '0;
          end else begin
            wdCount <= wdCount + 32'd1;
            if (wdExpire) flags[2] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resultErrCount    = errCount;
  assign resultFirstErrIdx = firstErrIdx;
  assign resultFlags       = flags;

endmodule

// File: tb/tb_smi_mem_lib_fuzz_test_data_checker.sv
// Directed bench for the fuzz test data checker: hand-computed result
// records for clean, mismatching, short-tail, framing, timeout and length cases.
module tb_smi_mem_lib_fuzz_test_data_checker;

  logic        clk;
  logic        srst;
  logic        paramsValid;
  logic [63:0] paramBaseAddr;
  logic [31:0] paramByteLength;
  logic [63:0] paramDataInit;
  logic [63:0] paramDataIncr;
  logic        paramsStop;
  logic        dataValid;
  logic [63:0] dataWord;
  logic        dataEof;
  logic        dataStop;
  logic        resultValid;
  logic [31:0] resultErrCount;
  logic [31:0] resultFirstErrIdx;
  logic [2:0]  resultFlags;
  logic        resultStop;

  int checks = 0;
  int failures = 0;

  smi_mem_lib_fuzz_test_data_checker #(
    .MaxBurstLength(8192),
    .TimeoutCycles (8)
  ) dut (
    .clk              (clk),
    .srst             (srst),
    .paramsValid      (paramsValid),
    .paramBaseAddr    (paramBaseAddr),
    .paramByteLength  (paramByteLength),
    .paramDataInit    (paramDataInit),
    .paramDataIncr    (paramDataIncr),
    .paramsStop       (paramsStop),
    .dataValid        (dataValid),
    .dataWord         (dataWord),
    .dataEof          (dataEof),
    .dataStop         (dataStop),
    .resultValid      (resultValid),
    .resultErrCount   (resultErrCount),
    .resultFirstErrIdx(resultFirstErrIdx),
    .resultFlags      (resultFlags),
    .resultStop       (resultStop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sendParams(input logic [31:0] len, input logic [63:0] init,
                            input logic [63:0] inc);
    int n = 0;
    paramsValid     = 1'b1;
    paramBaseAddr   = 64'h1000;
    paramByteLength = len;
    paramDataInit   = init;
    paramDataIncr   = inc;
    while (paramsStop && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("params_wait", 1'b1, 1'b0);
    @(negedge clk);
    paramsValid = 1'b0;
  endtask

  task automatic sendWord(input logic [63:0] w, input logic eof);
    int n = 0;
    dataValid = 1'b1;
    dataWord  = w;
    dataEof   = eof;
    while (dataStop && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("data_wait", 1'b1, 1'b0);
    @(negedge clk);
    dataValid = 1'b0;
    dataEof   = 1'b0;
  endtask

  task automatic getResult(input string tag, input logic [31:0] eErr,
                           input logic [31:0] eIdx, input logic [2:0] eFlags);
    int n = 0;
    while (!resultValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, resultValid, 1'b1);
    chk({tag, "_err"}, resultErrCount, eErr);
    chk({tag, "_idx"}, resultFirstErrIdx, eIdx);
    chk({tag, "_flags"}, resultFlags, eFlags);
    resultStop = 1'b0;
    @(negedge clk);
    resultStop = 1'b1;
    chk({tag, "_done"}, {resultValid, paramsStop}, 2'b00);
  endtask

  initial begin
    srst = 1'b1;
    paramsValid = 1'b0;
    paramBaseAddr = '0;
    paramByteLength = '0;
    paramDataInit = '0;
    paramDataIncr = '0;
    dataValid = 1'b0;
    dataWord = '0;
    dataEof = 1'b0;
    resultStop = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stops", {paramsStop, dataStop, resultValid}, 3'b110);
    srst = 1'b0;
    @(negedge clk);
    chk("idle_stops", {paramsStop, dataStop, resultValid}, 3'b010);

    // Clean 8-word counter burst
    sendParams(32'd64, 64'd0, 64'd1);
    chk("check_stops", {paramsStop, dataStop}, 2'b10);
    for (int i = 0; i < 8; i++) sendWord(64'(i), i == 7);
    getResult("clean", 32'd0, 32'hFFFFFFFF, 3'b000);

    // Short tail: upper bytes of word 2 ignored
    sendParams(32'd20, 64'h100, 64'h10);
    sendWord(64'h100, 1'b0);
    sendWord(64'h110, 1'b0);
    sendWord(64'hDEADBEEF_00000120, 1'b1);
    getResult("tail", 32'd0, 32'hFFFFFFFF, 3'b000);

    // Short tail with a mismatch in the compared bytes
    sendParams(32'd12, 64'd0, 64'd1);
    sendWord(64'd0, 1'b0);
    sendWord(64'hAAAAAAAA_00000101, 1'b1);
    getResult("tailbad", 32'd1, 32'd1, 3'b000);

    // Single bad word
    sendParams(32'd64, 64'd0, 64'd1);
    for (int i = 0; i < 8; i++) sendWord((i == 3) ? 64'hFF : 64'(i), i == 7);
    getResult("bad3", 32'd1, 32'd3, 3'b000);

    // Two bad words, first index kept
    sendParams(32'd32, 64'd0, 64'd1);
    sendWord(64'd0, 1'b0);
    sendWord(64'd9, 1'b0);
    sendWord(64'd2, 1'b0);
    sendWord(64'd7, 1'b1);
    getResult("bad2", 32'd2, 32'd1, 3'b000);

    // Expected value wraps modulo 2^64
    sendParams(32'd16, 64'hFFFFFFFF_FFFFFFFF, 64'd1);
    sendWord(64'hFFFFFFFF_FFFFFFFF, 1'b0);
    sendWord(64'd0, 1'b1);
    getResult("wrap", 32'd0, 32'hFFFFFFFF, 3'b000);

    // Early eof
    sendParams(32'd32, 64'd0, 64'd1);
    sendWord(64'd0, 1'b0);
    sendWord(64'd1, 1'b1);
    chk("early_dstop", dataStop, 1'b1);
    getResult("early", 32'd0, 32'hFFFFFFFF, 3'b010);

    // Missing eof, drain to the real eof
    sendParams(32'd32, 64'd0, 64'd1);
    for (int i = 0; i < 4; i++) sendWord(64'(i), 1'b0);
    sendWord(64'd4, 1'b0);
    chk("drain_busy", {resultValid, dataStop}, 2'b00);
    sendWord(64'd5, 1'b1);
    getResult("late", 32'd0, 32'hFFFFFFFF, 3'b010);

    // Watchdog: 8 idle cycles after one word
    sendParams(32'd16, 64'd0, 64'd1);
    sendWord(64'd0, 1'b0);
    repeat (7) @(negedge clk);
    chk("wd_pre", resultValid, 1'b0);
    @(negedge clk);
    chk("wd_fire", resultValid, 1'b1);
    getResult("wd", 32'd0, 32'hFFFFFFFF, 3'b100);

    // Over-length burst
    sendParams(32'd9000, 64'd0, 64'd1);
    chk("long_dstop", dataStop, 1'b1);
    getResult("long", 32'd0, 32'hFFFFFFFF, 3'b001);

    // Zero-length burst
    sendParams(32'd0, 64'd0, 64'd1);
    chk("zero_dstop", dataStop, 1'b1);
    getResult("zero", 32'd0, 32'hFFFFFFFF, 3'b000);

    // Result held under backpressure
    sendParams(32'd8, 64'd0, 64'd1);
    sendWord(64'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_err", resultErrCount, 32'd1);
      chk("hold_misc", {resultValid, paramsStop, dataStop, resultFlags,
                        resultFirstErrIdx}, {3'b111, 3'b000, 32'd0});
      @(negedge clk);
    end
    getResult("hold", 32'd1, 32'd0, 3'b000);

    // Reset mid-burst abandons the test
    sendParams(32'd64, 64'd0, 64'd1);
    sendWord(64'd0, 1'b0);
    sendWord(64'd99, 1'b0);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("abandon", {resultValid, paramsStop, dataStop}, 3'b001);
    repeat (12) @(negedge clk);
    chk("abandon_quiet", resultValid, 1'b0);
    sendParams(32'd8, 64'd3, 64'd1);
    sendWord(64'd3, 1'b1);
    getResult("after_rst", 32'd0, 32'hFFFFFFFF, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
